// File: rtl/vga_pkg.sv
// Shared types and constants for the pattern datapath: scheduler states, the
// fade range and the physical RGB bit positions of the {R1,G1,B1,R0,G0,B0} pin map.
package vga_pkg;

  typedef enum logic [1:0] {
    SHOW     = 2'd0,
    FADE_OUT = 2'd1,
    SWITCH   = 2'd2,
    FADE_IN  = 2'd3
  } sched_state_e;

  localparam logic [1:0] FADE_MAX = 2'd3;

  localparam int RGB_R1 = 5;
  localparam int RGB_G1 = 4;
  localparam int RGB_B1 = 3;
  localparam int RGB_R0 = 2;
  localparam int RGB_G0 = 1;
  localparam int RGB_B0 = 0;

  // floor(c * lvl / 3) for one 2-bit channel; product fits in 4 bits (max 9)
  function automatic logic [1:0] dim_chan(input logic [1:0] c, input logic [1:0] lvl);
    logic [3:0] prod;
    logic [3:0] quot;
    prod = {2'b00, c} * {2'b00, lvl};
    quot = prod / 4'd3;
    return quot[1:0];
  endfunction

endpackage

// File: rtl/rgb_dimmer.sv
// Combinational brightness scaler for a 6-bit {R1,G1,B1,R0,G0,B0} colour.
// Channels are split across the pin map, so each one is reassembled from its MSB/LSB pins.
module rgb_dimmer
  import vga_pkg::*;
(
  input  logic [5:0] rgb_i,
  input  logic [1:0] level_i,
  output logic [5:0] rgb_o
);

  always_comb begin
    rgb_o = '0;
    {rgb_o[RGB_R1], rgb_o[RGB_R0]} = dim_chan({rgb_i[RGB_R1], rgb_i[RGB_R0]}, level_i);
    {rgb_o[RGB_G1], rgb_o[RGB_G0]} = dim_chan({rgb_i[RGB_G1], rgb_i[RGB_G0]}, level_i);
    {rgb_o[RGB_B1], rgb_o[RGB_B0]} = dim_chan({rgb_i[RGB_B1], rgb_i[RGB_B0]}, level_i);
  end

endmodule

// File: rtl/pattern_scheduler.sv
// Frame-synchronous pattern sequencer: holds a pattern for a dwell time, then fades
// out, switches pattern on one black frame, and fades back in.
module pattern_scheduler
  import vga_pkg::*;
#(
  parameter int NUM_PATTERNS     = 4,
  parameter int DWELL_FRAMES     = 300,
  parameter int FADE_STEP_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       pause,
  input  logic       resume,
  input  logic       auto_en,
  input  logic       next_req,
  input  logic [5:0] rgb_in,
  output logic [1:0] pattern_select,
  output logic [1:0] fade_level,
  output logic [5:0] rgb_out,
  output logic       busy
);

  localparam int DW_W = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
  localparam int ST_W = (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;
  localparam logic [DW_W-1:0] DW_LAST  = DW_W'(DWELL_FRAMES - 1);
  localparam logic [ST_W-1:0] ST_LAST  = ST_W'(FADE_STEP_FRAMES - 1);
  localparam logic [1:0]      SEL_LAST = 2'(NUM_PATTERNS - 1);

  sched_state_e    state_q;
  logic [DW_W-1:0] dwell_q;
  logic [ST_W-1:0] step_q;
  logic [1:0]      level_q, sel_q, sel_d;
  logic            paused_q, pending_q, req_q;
  logic            req_edge, tick;

  assign req_edge = next_req & ~req_q;
  assign tick     = frame_start & ~paused_q;
  assign sel_d    = (sel_q == SEL_LAST) ? 2'd0 : sel_q + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SHOW;
      dwell_q   <= '0;
      step_q    <= '0;
      level_q   <= FADE_MAX;
      sel_q     <= 2'd0;
      paused_q  <= 1'b0;
      pending_q <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      req_q <= next_req;
      if (pause)       paused_q <= 1'b1;
      else if (resume) paused_q <= 1'b0;
      if (req_edge)    pending_q <= 1'b1;

      if (tick) begin
        unique case (state_q)
          SHOW: begin
            if (pending_q || (auto_en && dwell_q == DW_LAST)) begin
              state_q   <= FADE_OUT;
              dwell_q   <= '0;
              step_q    <= '0;
              // a fresh edge arriving on the consuming frame stays queued
              pending_q <= req_edge;
            end else if (dwell_q != DW_LAST) begin
              dwell_q <= dwell_q + 1'b1;
            end
          end
          FADE_OUT: begin
            if (step_q == ST_LAST) begin
              step_q  <= '0;
              level_q <= level_q - 2'd1;
              if (level_q == 2'd1) state_q <= SWITCH;
            end else begin
              step_q <= step_q + 1'b1;
            end
          end
          SWITCH: begin
            sel_q   <= sel_d;
            step_q  <= '0;
            state_q <= FADE_IN;
          end
          FADE_IN: begin
            if (step_q == ST_LAST) begin
              step_q  <= '0;
              level_q <= level_q + 2'd1;
              if (level_q == FADE_MAX - 2'd1) begin
                state_q <= SHOW;
                dwell_q <= '0;
              end
            end else begin
              step_q <= step_q + 1'b1;
            end
          end
          default: state_q <= SHOW;
        endcase
      end
    end
  end

  assign pattern_select = sel_q;
  assign fade_level     = level_q;
  assign busy           = (state_q != SHOW);

  rgb_dimmer u_dim (
    .rgb_i   (rgb_in),
    .level_i (level_q),
    .rgb_o   (rgb_out)
  );

endmodule
